// File: rtl/decode_pkg.sv
// Shared types and MIPS-style opcode constants for the decode stage.
// Used by decode_logic and decode_stage (optional macro: DECODE_SCOREBOARD_EN).
package decode_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;

    typedef enum logic [3:0] {
        ALU_R   = 4'd0,
        ALU_I   = 4'd1,
        LOAD    = 4'd2,
        STORE   = 4'd3,
        BRANCH  = 4'd4,
        JUMP    = 4'd5,
        JAL     = 4'd6,
        BC      = 4'd7,
        NOP     = 4'd8,
        ILLEGAL = 4'd9
    } op_class_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DEC   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLEZ  = 6'b000110;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BC    = 6'b110010;

    // Class of ops whose rt field is a register source rather than a destination.
    function automatic logic classReadsRt(input op_class_t cls);
        return (cls == ALU_R) || (cls == STORE) || (cls == BRANCH);
    endfunction

endpackage

// File: rtl/decode_logic.sv
// Purely combinational instruction decoder: instruction word -> decoded op fields.
module decode_logic
    import decode_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [XLEN-1:0]   i_cmd,
    output op_class_t         o_class,
    output logic [5:0]        o_funct,
    output logic [REG_AW-1:0] o_rs,
    output logic [REG_AW-1:0] o_rt,
    output logic [REG_AW-1:0] o_rd,
    output logic              o_we,
    output logic [XLEN-1:0]   o_imm,
    output logic              o_readsRt
);

    localparam logic [REG_AW-1:0] LINK_REG = REG_AW'(31);

    logic [5:0]        w_opcode;
    logic [15:0]       w_imm16;
    logic [REG_AW-1:0] w_rdField;
    logic              w_writes;
    logic              w_zeroExt;

    assign w_opcode  = i_cmd[31:26];
    assign w_imm16   = i_cmd[15:0];
    assign w_rdField = REG_AW'(i_cmd[15:11]);
    assign o_rs      = REG_AW'(i_cmd[25:21]);
    assign o_rt      = REG_AW'(i_cmd[20:16]);

    always_comb begin
        o_class   = ILLEGAL;
        o_funct   = w_opcode;
        o_rd      = '0;
        w_writes  = 1'b0;
        w_zeroExt = 1'b0;
        // The all-zero word would otherwise decode as SLL r0; treat it as a true NOP.
        if (i_cmd == '0) begin
            o_class = NOP;
            o_funct = 6'd0;
        end else begin
            case (w_opcode)
                OP_RTYPE: begin
                    o_class  = ALU_R;
                    o_funct  = i_cmd[5:0];
                    o_rd     = w_rdField;
                    w_writes = 1'b1;
                end
                OP_J:   o_class = JUMP;
                OP_JAL: begin
                    o_class  = JAL;
                    o_rd     = LINK_REG;
                    w_writes = 1'b1;
                end
                OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: o_class = BRANCH;
                OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LUI: begin
                    o_class  = ALU_I;
                    o_rd     = o_rt;
                    w_writes = 1'b1;
                end
                OP_ANDI, OP_ORI, OP_XORI: begin
                    o_class   = ALU_I;
                    o_rd      = o_rt;
                    w_writes  = 1'b1;
                    w_zeroExt = 1'b1;
                end
                OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                    o_class  = LOAD;
                    o_rd     = o_rt;
                    w_writes = 1'b1;
                end
                OP_SB, OP_SH, OP_SW: o_class = STORE;
                OP_BC:   o_class = BC;
                default: o_class = ILLEGAL;
            endcase
        end
    end

    assign o_we      = w_writes && (o_rd != '0);
    assign o_imm     = w_zeroExt ? {{(XLEN-16){1'b0}}, w_imm16}
                                 : {{(XLEN-16){w_imm16[15]}}, w_imm16};
    assign o_readsRt = classReadsRt(o_class);

endmodule

// File: rtl/decode_stage.sv
// Decode stage: requests fetches, decodes the returned word and hands one op to execute.
// Define DECODE_SCOREBOARD_EN to add the pending-write scoreboard and RAW-hazard stalls.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    output logic              fetch_en,
    input  logic              fetch_done,
    input  logic [XLEN-1:0]   fetch_cmd,
    input  logic [XLEN-1:0]   fetch_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [3:0]        out_class,
    output logic [5:0]        out_funct,
    output logic [REG_AW-1:0] out_rs,
    output logic [REG_AW-1:0] out_rt,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_we,
    output logic [XLEN-1:0]   out_imm,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd
);

    state_t            r_state;
    state_t            w_nextState;
    logic              w_issue;
    logic              w_fetchEnNext;
    logic              w_irLoad;
    logic              w_hazard;

    logic              r_fetchEn;
    logic [XLEN-1:0]   r_irCmd;
    logic [XLEN-1:0]   r_irPc;
    logic              r_outValid;
    logic [XLEN-1:0]   r_outPc;
    op_class_t         r_outClass;
    logic [5:0]        r_outFunct;
    logic [REG_AW-1:0] r_outRs;
    logic [REG_AW-1:0] r_outRt;
    logic [REG_AW-1:0] r_outRd;
    logic              r_outWe;
    logic [XLEN-1:0]   r_outImm;

    op_class_t         w_decClass;
    logic [5:0]        w_decFunct;
    logic [REG_AW-1:0] w_decRs;
    logic [REG_AW-1:0] w_decRt;
    logic [REG_AW-1:0] w_decRd;
    logic              w_decWe;
    logic [XLEN-1:0]   w_decImm;
    logic              w_decReadsRt;

    decode_logic #(
        .XLEN   (XLEN),
        .REG_AW (REG_AW)
    ) u_decode (
        .i_cmd     (r_irCmd),
        .o_class   (w_decClass),
        .o_funct   (w_decFunct),
        .o_rs      (w_decRs),
        .o_rt      (w_decRt),
        .o_rd      (w_decRd),
        .o_we      (w_decWe),
        .o_imm     (w_decImm),
        .o_readsRt (w_decReadsRt)
    );

`ifdef DECODE_SCOREBOARD_EN
    localparam int NREG = 1 << REG_AW;

    logic [NREG-1:0] r_pending;
    logic [NREG-1:0] w_setMask;
    logic [NREG-1:0] w_clrMask;
    logic [NREG-1:0] w_pendingLive;

    always_comb begin
        w_setMask = '0;
        w_clrMask = '0;
        if (w_issue && w_decWe) begin
            w_setMask[w_decRd] = 1'b1;
        end
        if (wb_valid) begin
            w_clrMask[wb_rd] = 1'b1;
        end
        w_setMask[0] = 1'b0;
    end

    // A writeback landing this cycle releases its register immediately, so the
    // waiting consumer issues on the very next edge.
    assign w_pendingLive = r_pending & ~w_clrMask;
    assign w_hazard      = w_pendingLive[w_decRs] ||
                           (w_decReadsRt && w_pendingLive[w_decRt]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pendingLive | w_setMask;
        end
    end
`else
    logic w_unusedWb;

    assign w_hazard   = 1'b0;
    assign w_unusedWb = wb_valid ^ (^wb_rd) ^ w_decReadsRt;
`endif

    always_comb begin
        w_nextState   = r_state;
        w_issue       = 1'b0;
        w_fetchEnNext = 1'b0;
        w_irLoad      = 1'b0;
        // A redirect with a fetch still outstanding must swallow that response in DRAIN.
        if (flush) begin
            if ((r_state == WAIT && !fetch_done) || r_state == DRAIN) begin
                w_nextState = DRAIN;
            end else begin
                w_nextState = IDLE;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    w_fetchEnNext = 1'b1;
                    w_nextState   = WAIT;
                end
                WAIT: begin
                    if (fetch_done) begin
                        w_irLoad    = 1'b1;
                        w_nextState = DEC;
                    end
                end
                DEC: begin
                    if (!w_hazard && (!r_outValid || out_ready)) begin
                        w_issue       = 1'b1;
                        w_fetchEnNext = 1'b1;
                        w_nextState   = WAIT;
                    end
                end
                DRAIN: begin
                    if (fetch_done) begin
                        w_nextState = IDLE;
                    end
                end
                default: w_nextState = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetchEn  <= 1'b0;
            r_irCmd    <= '0;
            r_irPc     <= '0;
            r_outValid <= 1'b0;
            r_outPc    <= '0;
            r_outClass <= ALU_R;
            r_outFunct <= '0;
            r_outRs    <= '0;
            r_outRt    <= '0;
            r_outRd    <= '0;
            r_outWe    <= 1'b0;
            r_outImm   <= '0;
        end else begin
            r_fetchEn <= w_fetchEnNext;
            if (w_irLoad) begin
                r_irCmd <= fetch_cmd;
                r_irPc  <= fetch_pc;
            end
            if (flush) begin
                r_outValid <= 1'b0;
            end else if (w_issue) begin
                r_outValid <= 1'b1;
            end else if (r_outValid && out_ready) begin
                r_outValid <= 1'b0;
            end
            if (w_issue) begin
                r_outPc    <= r_irPc;
                r_outClass <= w_decClass;
                r_outFunct <= w_decFunct;
                r_outRs    <= w_decRs;
                r_outRt    <= w_decRt;
                r_outRd    <= w_decRd;
                r_outWe    <= w_decWe;
                r_outImm   <= w_decImm;
            end
        end
    end

    assign fetch_en  = r_fetchEn;
    assign out_valid = r_outValid;
    assign out_pc    = r_outPc;
    assign out_class = r_outClass;
    assign out_funct = r_outFunct;
    assign out_rs    = r_outRs;
    assign out_rt    = r_outRt;
    assign out_rd    = r_outRd;
    assign out_we    = r_outWe;
    assign out_imm   = r_outImm;

endmodule
